// File: rtl/clarke_pkg.sv
// Shared constants and types for the forward and inverse Clarke transforms.
// Build option: INV_CLARKE_SAT_EN selects saturation in inv_clarke (not used here).
package clarke_pkg;

  localparam longint PPB            = 64'd1_000_000_000;
  localparam longint SQRT3_HALF_PPB = 64'd866_025_404;
  localparam longint INV_SQRT3_PPB  = 64'd577_350_269;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    SUM,
    HOLD
  } inv_clarke_state_t;

  // round(sqrt(3)/2 * 2**q), evaluated in integer arithmetic so it folds at elaboration
  function automatic int k_from_q(input int q);
    longint scaled;
    scaled = SQRT3_HALF_PPB * (longint'(1) << q);
    return int'((scaled + PPB / 2) / PPB);
  endfunction

  function automatic int inv_sqrt3_from_q(input int q);
    longint scaled;
    scaled = INV_SQRT3_PPB * (longint'(1) << q);
    return int'((scaled + PPB / 2) / PPB);
  endfunction

endpackage

// File: rtl/inv_clarke_sat_clip.sv
// Signed clamp from IN_W to OUT_W bits with a clip flag.
// Only compiled when INV_CLARKE_SAT_EN is defined, the one build that uses it.
`ifdef INV_CLARKE_SAT_EN
module sat_clip #(
  parameter int IN_W  = 34,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clipped
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout    = din[OUT_W-1:0];
    clipped = 1'b0;
    if (din > MAX_V) begin
      dout    = MAX_V[OUT_W-1:0];
      clipped = 1'b1;
    end else if (din < MIN_V) begin
      dout    = MIN_V[OUT_W-1:0];
      clipped = 1'b1;
    end
  end

endmodule
`endif

// File: rtl/inv_clarke.sv
// Inverse Clarke transform (alpha, beta) -> (a, b, c), one shared multiplier, 4-cycle FSM.
// Build option: INV_CLARKE_SAT_EN clamps b and c and drives sat; otherwise they wrap.
module inv_clarke
  import clarke_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int Q_BITS  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [D_WIDTH-1:0] alpha,
  input  logic signed [D_WIDTH-1:0] beta,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [D_WIDTH-1:0] a,
  output logic signed [D_WIDTH-1:0] b,
  output logic signed [D_WIDTH-1:0] c,
  output logic                      sat
);

  localparam int P_W   = D_WIDTH + Q_BITS + 1;
  localparam int S_W   = D_WIDTH + 2;
  localparam int K_INT = k_from_q(Q_BITS);
  localparam logic signed [Q_BITS:0] K = K_INT[Q_BITS:0];

  inv_clarke_state_t state_q, state_d;
  logic signed [D_WIDTH-1:0] alpha_q, alpha_d;
  logic signed [D_WIDTH-1:0] beta_q, beta_d;
  logic signed [D_WIDTH:0]   bk_q, bk_d;
  logic signed [D_WIDTH-1:0] half_q, half_d;
  logic signed [D_WIDTH-1:0] a_q, a_d;
  logic signed [D_WIDTH-1:0] b_q, b_d;
  logic signed [D_WIDTH-1:0] c_q, c_d;
  logic                      sat_q, sat_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;

  logic signed [P_W-1:0]     prod;
  logic signed [S_W-1:0]     b_wide;
  logic signed [S_W-1:0]     c_wide;
  logic signed [D_WIDTH-1:0] b_red;
  logic signed [D_WIDTH-1:0] c_red;
  logic                      sat_now;
  logic                      unused_bits;

  always_comb begin
    prod   = P_W'(beta_q) * P_W'(K);
    b_wide = -S_W'(half_q) + S_W'(bk_q);
    c_wide = -S_W'(half_q) - S_W'(bk_q);
  end

`ifdef INV_CLARKE_SAT_EN
  logic b_clip;
  logic c_clip;

  sat_clip #(.IN_W(S_W), .OUT_W(D_WIDTH)) u_clip_b (
    .din     (b_wide),
    .dout    (b_red),
    .clipped (b_clip)
  );

  sat_clip #(.IN_W(S_W), .OUT_W(D_WIDTH)) u_clip_c (
    .din     (c_wide),
    .dout    (c_red),
    .clipped (c_clip)
  );

  assign sat_now     = b_clip | c_clip;
  assign unused_bits = ^prod[Q_BITS-1:0];
`else
  assign b_red       = b_wide[D_WIDTH-1:0];
  assign c_red       = c_wide[D_WIDTH-1:0];
  assign sat_now     = 1'b0;
  assign unused_bits = ^{prod[Q_BITS-1:0], b_wide[S_W-1:D_WIDTH], c_wide[S_W-1:D_WIDTH]};
`endif

  always_comb begin
    state_d     = state_q;
    alpha_d     = alpha_q;
    beta_d      = beta_q;
    bk_d        = bk_q;
    half_d      = half_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_ready_q && in_valid) begin
          alpha_d = alpha;
          beta_d  = beta;
          state_d = MUL;
        end
      end
      MUL: begin
        // Keeping bits [Q_BITS +: D_WIDTH+1] is the arithmetic shift; the result always fits.
        bk_d    = prod[Q_BITS +: D_WIDTH+1];
        half_d  = alpha_q >>> 1;
        state_d = SUM;
      end
      SUM: begin
        a_d         = alpha_q;
        b_d         = b_red;
        c_d         = c_red;
        sat_d       = sat_now;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alpha_q     <= '0;
      beta_q      <= '0;
      bk_q        <= '0;
      half_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      alpha_q     <= alpha_d;
      beta_q      <= beta_d;
      bk_q        <= bk_d;
      half_q      <= half_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_inv_clarke.sv
// Directed testbench for inv_clarke (D_WIDTH=32, Q_BITS=10).
// Overflow expectations follow INV_CLARKE_SAT_EN as seen by this compile.
module tb_inv_clarke;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] alpha;
  logic signed [31:0] beta;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic signed [31:0] c;
  logic               sat;

  int checks;
  int errors;

  inv_clarke #(.D_WIDTH(32), .Q_BITS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alpha     (alpha),
    .beta      (beta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, performs one input handshake, then waits for out_valid.
  task automatic run_txn(input logic signed [31:0] al, input logic signed [31:0] be,
                         output int lat, output bit seen);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    alpha    = al;
    beta     = be;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    seen = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++;
    if (a !== 32'sd0 || b !== 32'sd0 || c !== 32'sd0 || sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got a=%0d b=%0d c=%0d sat=%0b want 0 0 0 0", a, b, c, sat);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_positive_alpha();
    int lat;
    bit seen;
    out_ready = 1'b1;
    run_txn(32'sd1024, 32'sd0, lat, seen);
    checks++;
    if (!seen || lat != 3) begin errors++; $display("[TB] FAIL pos_alpha_latency: got %0d (seen=%0b) want 3", lat, seen); end
    checks++;
    if (a !== 32'sd1024) begin errors++; $display("[TB] FAIL pos_alpha_a: got %0d want 1024", a); end
    checks++;
    if (b !== -32'sd512 || c !== -32'sd512) begin
      errors++;
      $display("[TB] FAIL pos_alpha_bc: got b=%0d c=%0d want -512 -512", b, c);
    end
    checks++;
    if (sat !== 1'b0) begin errors++; $display("[TB] FAIL pos_alpha_sat: got %0b want 0", sat); end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pos_alpha_release: got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_beta_sign();
    int lat;
    bit seen;
    run_txn(32'sd0, 32'sd1024, lat, seen);
    checks++;
    if (!seen || a !== 32'sd0 || b !== 32'sd887 || c !== -32'sd887) begin
      errors++;
      $display("[TB] FAIL pos_beta: got a=%0d b=%0d c=%0d seen=%0b want 0 887 -887", a, b, c, seen);
    end
    step();
    run_txn(32'sd0, -32'sd1024, lat, seen);
    checks++;
    if (!seen || b !== -32'sd887 || c !== 32'sd887) begin
      errors++;
      $display("[TB] FAIL neg_beta: got b=%0d c=%0d seen=%0b want -887 887", b, c, seen);
    end
    step();
  endtask

  task automatic test_floor_rounding();
    int lat;
    bit seen;
    run_txn(-32'sd3, 32'sd0, lat, seen);
    checks++;
    if (!seen || a !== -32'sd3 || b !== 32'sd2 || c !== 32'sd2) begin
      errors++;
      $display("[TB] FAIL floor_round: got a=%0d b=%0d c=%0d seen=%0b want -3 2 2", a, b, c, seen);
    end
    step();
  endtask

  task automatic test_overflow();
    int lat;
    bit seen;
    logic signed [31:0] exp_b;
    logic               exp_sat;
`ifdef INV_CLARKE_SAT_EN
    exp_b   = 32'sd2147483647;
    exp_sat = 1'b1;
`else
    exp_b   = -32'sd1361051649;
    exp_sat = 1'b0;
`endif
    run_txn(32'sh8000_0000, 32'sh7fff_ffff, lat, seen);
    checks++;
    if (!seen || a !== 32'sh8000_0000) begin errors++; $display("[TB] FAIL ovf_a: got %0d seen=%0b want -2147483648", a, seen); end
    checks++;
    if (b !== exp_b) begin errors++; $display("[TB] FAIL ovf_b: got %0d want %0d", b, exp_b); end
    checks++;
    if (c !== -32'sd786431999) begin errors++; $display("[TB] FAIL ovf_c: got %0d want -786431999", c); end
    checks++;
    if (sat !== exp_sat) begin errors++; $display("[TB] FAIL ovf_sat: got %0b want %0b", sat, exp_sat); end
    step();
  endtask

  task automatic test_back_to_back();
    int hs_first;
    int hs_second;
    int outs;
    int guard;
    hs_first  = -1;
    hs_second = -1;
    outs      = 0;
    alpha     = 32'sd0;
    beta      = 32'sd1024;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (in_valid && in_ready) begin
        if (hs_first < 0) hs_first = cyc;
        else if (hs_second < 0) hs_second = cyc;
      end
      if (out_valid) begin
        outs++;
        checks++;
        if (b !== 32'sd887 || c !== -32'sd887) begin
          errors++;
          $display("[TB] FAIL b2b_values: got b=%0d c=%0d want 887 -887", b, c);
        end
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (hs_first < 0 || hs_second - hs_first != 4) begin
      errors++;
      $display("[TB] FAIL b2b_interval: got %0d want 4", hs_second - hs_first);
    end
    checks++;
    if (outs != 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d want 3", outs); end
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
  endtask

  task automatic test_backpressure_reset();
    int lat;
    bit seen;
    int stale;
    out_ready = 1'b0;
    run_txn(32'sd1024, 32'sd1024, lat, seen);
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL bp_valid: got 0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || a !== 32'sd1024 || b !== 32'sd375 || c !== -32'sd1399) begin
        errors++;
        $display("[TB] FAIL bp_hold: got v=%0b rdy=%0b a=%0d b=%0d c=%0d want 1 0 1024 375 -1399",
                 out_valid, in_ready, a, b, c);
      end
    end
    out_ready = 1'b1;
    step();
    // New sample, then reset while the FSM sits in MUL
    alpha    = 32'sd1024;
    beta     = 32'sd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || a !== 32'sd0 || b !== 32'sd0 || c !== 32'sd0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got v=%0b rdy=%0b a=%0d b=%0d c=%0d want 0 0 0 0 0",
               out_valid, in_ready, a, b, c);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_ready: got %0b want 1", in_ready); end
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) stale++;
      step();
    end
    checks++;
    if (stale != 0) begin errors++; $display("[TB] FAIL stale_output: got %0d valid cycles want 0", stale); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alpha     = '0;
    beta      = '0;
    test_reset();
    test_positive_alpha();
    test_beta_sign();
    test_floor_rounding();
    test_overflow();
    test_back_to_back();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_clarke.md
# inv_clarke

Inverse Clarke transform for the FOC output path: converts a stationary-frame vector (alpha, beta) into three phase references (a, b, c) for the PWM modulator. It is the counterpart of the forward Clarke stage and uses the same signed fixed-point format (D_WIDTH-bit integer samples, Q_BITS-fraction constants). The block is sequential and uses one shared multiplier. It has valid/ready handshakes on both sides, so it can sit between the inverse Park stage and the modulator with backpressure.

## Interface
- D_WIDTH, 32, width of every signed sample port
- Q_BITS, 10, fractional bits of the sqrt(3)/2 constant
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  the (alpha, beta) pair is valid
- in_ready  out  1  the block can accept a pair
- alpha  in  D_WIDTH  signed alpha component
- beta  in  D_WIDTH  signed beta component
- out_valid  out  1  a, b, c are valid
- out_ready  in  1  the consumer accepts a, b, c
- a, b, c  out  D_WIDTH  signed phase outputs
- sat  out  1  b or c was clipped for the current output; always 0 when saturation is compiled out

## Operation
- Equations:
  - a = alpha
  - b = -(alpha>>>1) + ((beta*K)>>>Q_BITS)
  - c = -(alpha>>>1) - ((beta*K)>>>Q_BITS)
  - K = round(0.86602540378 * 2**Q_BITS), which is 887 for Q_BITS=10.
- Arithmetic rules:
  - All shifts are arithmetic, which gives floor rounding.
  - The product is held at D_WIDTH+Q_BITS+1 bits.
  - The sums are held at D_WIDTH+2 bits.
  - Final reduction to D_WIDTH is either a wrap (truncate the MSBs) or a saturation, selected per the Configuration section.
- FSM states: IDLE, MUL, SUM, HOLD.
  - IDLE: in_ready=1. When in_valid=1, register alpha and beta, then go to MUL.
  - MUL: register beta*K >>> Q_BITS and alpha>>>1, then go to SUM.
  - SUM: compute a, b, c and sat into the output registers, then go to HOLD.
  - HOLD: out_valid=1. When out_ready=1, go to IDLE.
- in_ready is high only in IDLE. No new input is taken in the same cycle as an output handshake.
- While out_valid=1 and out_ready=0, a, b, c and sat hold stable.
- Reset values: state=IDLE, in_ready=0 during the reset cycle and 1 afterwards, out_valid=0, a=b=c=0, sat=0.

## Timing
- Cycle numbering: cycle 0 is the cycle with the input handshake.
- In cycle 0 the block is in IDLE and samples the input.
- MUL is cycle 1 and SUM is cycle 2.
- out_valid rises at the edge after cycle 2, so it is visible in cycle 3.
- Latency: 3 cycles from the input handshake to out_valid.
- Throughput: with out_ready held at 1, one sample every 4 cycles. The next in_ready is in the cycle after the output handshake.
- Reset asserted in any state: at the next edge the FSM returns to IDLE, out_valid goes to 0, and the in-flight sample is discarded with no output.
- in_valid arriving while the block is not in IDLE is ignored. The producer must hold the pair until in_ready.

## Configuration
- INV_CLARKE_SAT_EN
  - Defined: b and c are clamped to [-2**(D_WIDTH-1), 2**(D_WIDTH-1)-1], and sat=1 for that output if either value was clamped.
  - Undefined: b and c wrap to the low D_WIDTH bits, and sat is tied to 0.
- a is alpha passed through unchanged, so it never saturates.

## Structure
- Shared package clarke_pkg holds:
  - the function computing K from Q_BITS
  - the 1/sqrt(3) constant, shared with the forward transform
  - the state enum typedef inv_clarke_state_t
- One sub-module, sat_clip, is natural: a parameterised in/out-width signed clamp with a flag output. It is instantiated twice, once for b and once for c, only under INV_CLARKE_SAT_EN.

## Test plan
All scenarios use D_WIDTH=32 and Q_BITS=10.
- Positive alpha: alpha=1024, beta=0 -> a=1024, b=-512, c=-512, sat=0, with out_valid 3 cycles after the handshake.
- Positive beta: alpha=0, beta=1024 -> a=0, b=887, c=-887.
- Negative beta: alpha=0, beta=-1024 -> b=-887, c=887.
- Floor rounding: alpha=-3, beta=0 -> a=-3, b=2, c=2.
- Overflow: alpha=-2**31, beta=2**31-1.
  - With INV_CLARKE_SAT_EN defined: b=2147483647, c=-786431999, sat=1.
  - With it undefined: b=-1361051649, c=-786431999, sat=0.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> a, b, c stay stable and in_ready=0. Then assert rst for one cycle while in MUL -> out_valid=0 and outputs are 0 at the next edge, in_ready=1 the cycle after, and no stale output appears.
